// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - two-port (fetch/debug) arbiter for a single synchronous-read instruction memory
module imem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starved
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             f_pend_q, f_pend_d;
  logic             d_pend_q, d_pend_d;
  logic             starve_hit;

  assign starve_hit = (starve_cnt_q == CNT_MAX);

  // Per-cycle grant: fetch wins by default, debug wins once it has waited STARVE_MAX cycles.
  // Grants are gated by rst_n so nothing reaches the memory while reset is held.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (f_req && d_req) begin
        if (starve_hit) d_gnt = 1'b1;
        else            f_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Memory drive; the address idles at f_addr so it does not toggle needlessly.
  always_comb begin
    mem_en   = f_gnt | d_gnt;
    mem_addr = d_gnt ? d_addr : f_addr;
  end

  // Next-state: starvation counter and one-cycle response tracking.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (d_gnt) begin
      starve_cnt_d = '0;
    end else if (d_req && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
    f_pend_d = f_gnt;
    d_pend_d = d_gnt;
  end

  // State registers; reset drops any in-flight responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      f_pend_q     <= 1'b0;
      d_pend_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      f_pend_q     <= f_pend_d;
      d_pend_q     <= d_pend_d;
    end
  end

  // Responses: data is shared, rvalid alone qualifies it; a flush kills only this cycle's fetch response.
  always_comb begin
    f_rvalid = f_pend_q & ~f_flush;
    d_rvalid = d_pend_q;
    f_rdata  = mem_rdata;
    d_rdata  = mem_rdata;
    starved  = starve_hit;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              f_req, f_flush, d_req;
  logic [ADDR_W-1:0] f_addr, d_addr;
  logic              f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, starved;
  logic [DATA_W-1:0] f_rdata, d_rdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .starved(starved)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    return {5'h1A, a, 5'h05, ~a};
  endfunction

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_f(mem_addr);
  end

  // Advance to the next cycle: drive point just after the posedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; f_flush = 1'b0;
    f_addr = '0; d_addr = '0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; f_req = 1'b1; d_req = 1'b1; f_flush = 1'b0;
    f_addr = 11'd3; d_addr = 11'd9; mem_rdata = '0;
    sample();
    sample();
    checks++;
    if ({f_gnt, d_gnt, mem_en} !== 3'b000) begin
      errors++; $display("FAIL reset_gnt got %b exp 000", {f_gnt, d_gnt, mem_en});
    end
    checks++;
    if ({f_rvalid, d_rvalid, starved} !== 3'b000) begin
      errors++; $display("FAIL reset_valid got %b exp 000", {f_rvalid, d_rvalid, starved});
    end
    next_cycle();
    rst_n = 1'b1;
    sample();
    checks++;
    if ({f_gnt, d_gnt, mem_en, f_rvalid, d_rvalid} !== 5'b10100 || mem_addr !== 11'd3) begin
      errors++; $display("FAIL release_gnt got %b addr %h exp 10100 addr 003",
                         {f_gnt, d_gnt, mem_en, f_rvalid, d_rvalid}, mem_addr);
    end
    next_cycle();
    f_req = 1'b0; d_req = 1'b0;
    sample();
    checks++;
    if (f_rvalid !== 1'b1 || f_rdata !== mem_f(11'd3) || d_rvalid !== 1'b0) begin
      errors++; $display("FAIL release_rvalid got v%b d%h exp v1 d%h", f_rvalid, f_rdata, mem_f(11'd3));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      f_req  = (i < 3);
      f_addr = ADDR_W'(i);
      sample();
      if (i < 3) begin
        checks++;
        if (f_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== ADDR_W'(i)) begin
          errors++; $display("FAIL b2b_gnt%0d got g%b a%h exp g1 a%h", i, f_gnt, mem_addr, ADDR_W'(i));
        end
      end
      if (i > 0) begin
        checks++;
        if (f_rvalid !== 1'b1 || f_rdata !== mem_f(ADDR_W'(i - 1))) begin
          errors++; $display("FAIL b2b_data%0d got v%b d%h exp v1 d%h", i, f_rvalid, f_rdata,
                             mem_f(ADDR_W'(i - 1)));
        end
      end else begin
        checks++;
        if (f_rvalid !== 1'b0) begin
          errors++; $display("FAIL b2b_first_rvalid got %b exp 0", f_rvalid);
        end
      end
    end
    next_cycle();
    f_req = 1'b0;
  endtask

  task automatic test_starvation();
    logic exp_d;
    do_reset();
    f_req = 1'b1; d_req = 1'b1; f_addr = 11'h100; d_addr = 11'h200;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) next_cycle();
      sample();
      exp_d = ((i % 5) == 4);
      checks++;
      if ({f_gnt, d_gnt, starved} !== {~exp_d, exp_d, exp_d}) begin
        errors++; $display("FAIL starve_cyc%0d got fgnt%b dgnt%b starved%b exp fgnt%b dgnt%b starved%b",
                           i, f_gnt, d_gnt, starved, ~exp_d, exp_d, exp_d);
      end
    end
    next_cycle();
    f_req = 1'b0; d_req = 1'b0;
    sample();
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== mem_f(11'h200) || f_rvalid !== 1'b0) begin
      errors++; $display("FAIL starve_drvalid got dv%b d%h fv%b exp dv1 d%h fv0",
                         d_rvalid, d_rdata, f_rvalid, mem_f(11'h200));
    end
  endtask

  task automatic test_flush();
    do_reset();
    f_req = 1'b1; f_addr = 11'h10;
    sample();
    next_cycle();
    f_flush = 1'b1; f_addr = 11'h40;
    sample();
    checks++;
    if (f_rvalid !== 1'b0 || f_gnt !== 1'b1 || mem_addr !== 11'h40) begin
      errors++; $display("FAIL flush_kill got v%b g%b a%h exp v0 g1 a040", f_rvalid, f_gnt, mem_addr);
    end
    next_cycle();
    f_flush = 1'b0; f_req = 1'b0;
    sample();
    checks++;
    if (f_rvalid !== 1'b1 || f_rdata !== mem_f(11'h40)) begin
      errors++; $display("FAIL flush_next got v%b d%h exp v1 d%h", f_rvalid, f_rdata, mem_f(11'h40));
    end
  endtask

  task automatic test_debug_only();
    do_reset();
    d_req = 1'b1; d_addr = 11'h7FF; f_addr = 11'h001;
    sample();
    checks++;
    if ({f_gnt, d_gnt, mem_en} !== 3'b011 || mem_addr !== 11'h7FF) begin
      errors++; $display("FAIL dbg_gnt got %b a%h exp 011 a7ff", {f_gnt, d_gnt, mem_en}, mem_addr);
    end
    next_cycle();
    d_req = 1'b0; f_flush = 1'b1;
    sample();
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== mem_f(11'h7FF) || f_rvalid !== 1'b0) begin
      errors++; $display("FAIL dbg_data got dv%b d%h fv%b exp dv1 d%h fv0",
                         d_rvalid, d_rdata, f_rvalid, mem_f(11'h7FF));
    end
    next_cycle();
    f_flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic exp_d;
    do_reset();
    d_req = 1'b1; d_addr = 11'h005;
    sample();
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL mid_dgnt got %b exp 1", d_gnt);
    end
    rst_n = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (i == 2) rst_n = 1'b1;
      sample();
      checks++;
      if (d_rvalid !== 1'b0 || f_rvalid !== 1'b0) begin
        errors++; $display("FAIL mid_rvalid%0d got d%b f%b exp 0 0", i, d_rvalid, f_rvalid);
      end
    end
    next_cycle();
    f_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      sample();
      exp_d = (i == 4);
      checks++;
      if ({f_gnt, d_gnt} !== {~exp_d, exp_d}) begin
        errors++; $display("FAIL mid_cnt%0d got f%b d%b exp f%b d%b", i, f_gnt, d_gnt, ~exp_d, exp_d);
      end
    end
    next_cycle();
    f_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_starvation();
    test_flush();
    test_debug_only();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
